// File: rtl/dbus_arb_pkg.sv
// Shared types and defaults for the two-master data-bus arbiter.
// Contents:
//   type_dbus_arb_state_e : arbiter FSM states (IDLE, BUSY_M0, BUSY_M1)
//   type_dbus_master_e    : master identity used for the round-robin history
//   DBUS_ARB_TIMEOUT_DEF  : default slave timeout in cycles
package dbus_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_M0 = 2'd1,
    BUSY_M1 = 2'd2
  } type_dbus_arb_state_e;

  typedef enum logic {
    M0_LSU = 1'b0,
    M1_DMA = 1'b1
  } type_dbus_master_e;

  localparam int DBUS_ARB_TIMEOUT_DEF = 256;

endpackage

// File: rtl/dbus_arb_rr2.sv
// Two-input round-robin picker.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   req[1:0]   : request vector, bit 0 = M0 (LSU), bit 1 = M1 (DMA)
//   take       : the arbiter accepts the current pick this cycle; the
//                winner is recorded as last_grant at the edge
//   grant[1:0] : one-hot combinational pick, 0 when no request
module dbus_arb_rr2
  import dbus_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       take,
  output logic [1:0] grant
);

  type_dbus_master_e last_grant;

  // On a tie the master that did not win last time goes first.
  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = (last_grant == M1_DMA) ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

  // Reset history to M1 so the first tie after reset goes to the LSU.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= M1_DMA;
    end else if (take && (grant != 2'b00)) begin
      last_grant <= grant[1] ? M1_DMA : M0_LSU;
    end
  end

endmodule

// File: rtl/dbus_arbiter.sv
// Two-master arbiter in front of the single dbus slave port.
// Master 0 is the core LSU, master 1 the DMA/debug requester. A winner is
// picked round-robin in IDLE, its request fields are registered onto the
// slave side and held until the slave acks or the transaction times out.
// Ports:
//   clk, rst_n                 : clock, asynchronous active-low reset
//   mX_req_i/addr/wdata/we/be  : master X request, held until ack or err
//   mX_ack_o, mX_rdata_o       : completion pulse and read data (same cycle
//                                as s_ack_i), rdata is 0 without ack
//   mX_err_o                   : timeout pulse
//   s_req_o/addr/wdata/we/be   : registered slave request
//   s_ack_i, s_rdata_i         : slave completion and read data
//   grant_o                    : one-hot current owner (status)
module dbus_arbiter
  import dbus_arb_pkg::*;
#(
  parameter int TIMEOUT_CYC = DBUS_ARB_TIMEOUT_DEF,
  parameter int AW          = 32,
  parameter int DW          = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            m0_req_i,
  input  logic [AW-1:0]   m0_addr_i,
  input  logic [DW-1:0]   m0_wdata_i,
  input  logic            m0_we_i,
  input  logic [DW/8-1:0] m0_be_i,
  output logic            m0_ack_o,
  output logic            m0_err_o,
  output logic [DW-1:0]   m0_rdata_o,
  input  logic            m1_req_i,
  input  logic [AW-1:0]   m1_addr_i,
  input  logic [DW-1:0]   m1_wdata_i,
  input  logic            m1_we_i,
  input  logic [DW/8-1:0] m1_be_i,
  output logic            m1_ack_o,
  output logic            m1_err_o,
  output logic [DW-1:0]   m1_rdata_o,
  output logic            s_req_o,
  output logic [AW-1:0]   s_addr_o,
  output logic [DW-1:0]   s_wdata_o,
  output logic            s_we_o,
  output logic [DW/8-1:0] s_be_o,
  input  logic            s_ack_i,
  input  logic [DW-1:0]   s_rdata_i,
  output logic [1:0]      grant_o
);

  localparam int            CW       = $clog2(TIMEOUT_CYC);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYC - 1);

  type_dbus_arb_state_e state;
  logic [CW-1:0]        cnt;
  logic [1:0]           pick;
  logic                 in_idle;
  logic                 timeout_hit;
  logic                 done;

  assign in_idle = (state == IDLE);

  dbus_arb_rr2 u_rr2 (
    .clk   (clk),
    .rst_n (rst_n),
    .req   ({m1_req_i, m0_req_i}),
    .take  (in_idle),
    .grant (pick)
  );

  // A slave ack in the last counted cycle wins over the timeout.
  assign timeout_hit = !in_idle && (cnt == CNT_LAST) && !s_ack_i;
  assign done        = !in_idle && (s_ack_i || timeout_hit);

  assign m0_ack_o   = (state == BUSY_M0) && s_ack_i;
  assign m1_ack_o   = (state == BUSY_M1) && s_ack_i;
  assign m0_err_o   = (state == BUSY_M0) && timeout_hit;
  assign m1_err_o   = (state == BUSY_M1) && timeout_hit;
  assign m0_rdata_o = m0_ack_o ? s_rdata_i : '0;
  assign m1_rdata_o = m1_ack_o ? s_rdata_i : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      s_req_o   <= 1'b0;
      s_addr_o  <= '0;
      s_wdata_o <= '0;
      s_we_o    <= 1'b0;
      s_be_o    <= '0;
      grant_o   <= 2'b00;
    end else if (in_idle) begin
      // Winner's fields are sampled only here, at the grant edge.
      if (pick != 2'b00) begin
        state     <= pick[1] ? BUSY_M1 : BUSY_M0;
        cnt       <= '0;
        s_req_o   <= 1'b1;
        s_addr_o  <= pick[1] ? m1_addr_i  : m0_addr_i;
        s_wdata_o <= pick[1] ? m1_wdata_i : m0_wdata_i;
        s_we_o    <= pick[1] ? m1_we_i    : m0_we_i;
        s_be_o    <= pick[1] ? m1_be_i    : m0_be_i;
        grant_o   <= pick;
      end
    end else if (done) begin
      state   <= IDLE;
      s_req_o <= 1'b0;
      grant_o <= 2'b00;
    end else if (cnt != CNT_LAST) begin
      // Saturating count of cycles without an ack.
      cnt <= cnt + 1'b1;
    end
  end

endmodule
